fetch_controller: RTL and testbench

Instruction-fetch sequencer between the instruction memory and the decode stage of the RV32 core. Owns the program counter, issues word-aligned read requests to the instruction memory, buffers returned instructions in a small prefetch queue, and presents them to decode with a valid/ready handshake. Branch and jump targets (beq, jal, jalr) arrive as a redirect that flushes all speculative fetch state.

---
 rtl/fetch_controller.sv | 134 +++++++++++++
 tb/tb_fetch_controller.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for the RV32 core.
// Owns the fetch PC, issues word-aligned requests to instruction memory,
// buffers returned words with their PCs in a small prefetch queue, and
// presents the queue head to decode with a valid/ready handshake.
// A redirect flushes the queue and any in-flight response and reloads the PC.
// Optional feature macro: FETCH_ZERO_HALT_EN. When it is defined, a returned
// word of zero stops fetching (HALT) until the next redirect or reset.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic          running;
    logic          zero_word;
    logic          push;
    logic          pop;
    logic          accept;
    logic [CW:0]   occupancy;
    logic [CW:0]   limit;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_addr  = pc_q;
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

    // A request may only go out if its response is guaranteed a queue slot:
    // entries held plus the response in flight, minus the entry leaving now.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign limit     = DEPTH_C + {{CW{1'b0}}, inst_valid & inst_ready};
    assign imem_req  = !reset & running & !redirect_valid & (occupancy < limit);
    assign accept    = imem_req & imem_gnt;

    assign pop  = inst_valid & inst_ready & !redirect_valid;
    assign push = inflight & running & !redirect_valid & !zero_word;

`ifdef FETCH_ZERO_HALT_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;

    assign running   = (state == RUN);
    assign halted    = (state == HALT);
    assign zero_word = inflight & running & (imem_rdata == 32'h0000_0000);

    // Run/halt sequencing: a zero word ends the program, redirect restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else if (redirect_valid) begin
            state <= RUN;
        end else if (zero_word) begin
            state <= HALT;
        end
    end
`else
    assign running   = 1'b1;
    assign halted    = 1'b0;
    assign zero_word = 1'b0;
`endif

    // Fetch PC, in-flight tracking and prefetch queue; redirect flushes all speculative state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            resp_pc  <= 32'h0000_0000;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= 32'h0000_0000;
                q_pc[i]   <= 32'h0000_0000;
            end
        end else begin
            inflight <= accept;
            if (accept) begin
                resp_pc <= pc_q;
            end
            if (redirect_valid) begin
                pc_q   <= {redirect_pc[31:2], 2'b00};
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (accept) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    q_inst[wr_ptr] <= imem_rdata;
                    q_pc[wr_ptr]   <= resp_pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller.
// A behavioural memory returns a word derived from each address; the
// reference model is the program-order view: accepted request addresses and
// delivered instruction PCs must each advance by 4 and restart at every
// redirect target, with no more than DEPTH responses outstanding.
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    bit zero_mode = 1'b0;

    fetch_controller #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: nonzero word per address, or a short program followed by zeros
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (zero_mode && a >= 32'h0000_000C && a < 32'h0000_0100) begin
            return 32'h0000_0000;
        end
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) | 32'h0000_0001;
    endfunction

    task automatic applyStimulus(input bit g, input bit r, input bit rv, input logic [31:0] rp);
        imem_gnt       = g;
        inst_ready     = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    // One clock: memory answers an accepted request during the following cycle
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req && imem_gnt && !reset;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = acc ? mem_word(a) : $urandom;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values got req=%0b addr=%h valid=%0b inst=%h pc=%h halted=%0b expected 0/%h/0/0/0/0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, halted, RESET_PC);
        end
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("[TB] FAIL reset_first_req got req=%0b addr=%h expected 1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        // Reset mid-fetch, with a simultaneous redirect that must lose to reset
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== RESET_PC || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_midfetch got addr=%h req=%0b valid=%0b expected addr=%h req=1 valid=0",
                     imem_addr, imem_req, inst_valid, RESET_PC);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stale_resp got valid=%0b pc=%h expected valid=0", inst_valid, inst_pc);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== mem_word(RESET_PC)) begin
            failures++;
            $display("[TB] FAIL reset_first_inst got valid=%0b pc=%h inst=%h expected 1 pc=%h inst=%h",
                     inst_valid, inst_pc, inst, RESET_PC, mem_word(RESET_PC));
        end
        tick();
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] ea;
        logic [31:0] ep;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            ea = RESET_PC + 32'(4 * k);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== ea) begin
                failures++;
                $display("[TB] FAIL seq_req cycle=%0d got req=%0b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, ea);
            end
            checks++;
            if (k >= 2) begin
                ep = RESET_PC + 32'(4 * (k - 2));
                if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== mem_word(ep)) begin
                    failures++;
                    $display("[TB] FAIL seq_inst cycle=%0d got valid=%0b pc=%h inst=%h expected 1 pc=%h inst=%h",
                             k, inst_valid, inst_pc, inst, ep, mem_word(ep));
                end
            end else if (inst_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL seq_latency cycle=%0d got valid=%0b expected 0", k, inst_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          accepted;
        int          delivered;
        logic [31:0] ep;
        do_reset();
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            if (k >= 2) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== mem_word(RESET_PC)) begin
                    failures++;
                    $display("[TB] FAIL bp_head_stable cycle=%0d got valid=%0b pc=%h inst=%h expected 1 pc=%h",
                             k, inst_valid, inst_pc, inst, RESET_PC);
                end
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bp_no_req cycle=%0d got req=%0b expected 0", k, imem_req);
                end
            end
            if (imem_req && imem_gnt) accepted++;
            tick();
        end
        checks++;
        if (accepted != DEPTH) begin
            failures++;
            $display("[TB] FAIL bp_buffered got %0d entries expected %0d", accepted, DEPTH);
        end
        delivered = 0;
        ep = RESET_PC;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (inst_valid) begin
                checks++;
                if (inst_pc !== ep || inst !== mem_word(ep)) begin
                    failures++;
                    $display("[TB] FAIL bp_resume_order got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, ep, mem_word(ep));
                end
                ep = ep + 32'd4;
                delivered++;
            end
            tick();
        end
        checks++;
        if (delivered != 8) begin
            failures++;
            $display("[TB] FAIL bp_resume_rate got %0d deliveries expected 8", delivered);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k == 3, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0008) begin
                failures++;
                $display("[TB] FAIL gnt_hold cycle=%0d got req=%0b addr=%h expected req=1 addr=00000008", k, imem_req, imem_addr);
            end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_000C) begin
            failures++;
            $display("[TB] FAIL gnt_advance got req=%0b addr=%h expected req=1 addr=0000000c", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect();
        logic [31:0] ep;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0017);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0000_0004) begin
            failures++;
            $display("[TB] FAIL redir_cycle got req=%0b valid=%0b pc=%h expected req=0 valid=1 pc=00000004",
                     imem_req, inst_valid, inst_pc);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0014) begin
            failures++;
            $display("[TB] FAIL redir_flush got valid=%0b req=%0b addr=%h expected valid=0 req=1 addr=00000014",
                     inst_valid, imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redir_stale got valid=%0b pc=%h expected valid=0", inst_valid, inst_pc);
        end
        tick();
        ep = 32'h0000_0014;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== mem_word(ep)) begin
                failures++;
                $display("[TB] FAIL redir_target got valid=%0b pc=%h inst=%h expected 1 pc=%h inst=%h",
                         inst_valid, inst_pc, inst, ep, mem_word(ep));
            end
            ep = ep + 32'd4;
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL wrap_top got req=%0b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL wrap_zero got req=%0b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL wrap_inst_top got valid=%0b pc=%h expected 1 pc=fffffffc", inst_valid, inst_pc);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0000 || inst !== mem_word(32'h0)) begin
            failures++;
            $display("[TB] FAIL wrap_inst_zero got valid=%0b pc=%h inst=%h expected 1 pc=00000000 inst=%h",
                     inst_valid, inst_pc, inst, mem_word(32'h0));
        end
        tick();
    endtask

    task automatic test_zero_words();
        int          delivered;
        logic [31:0] ep;
        zero_mode = 1'b1;
        do_reset();
        delivered = 0;
        ep = RESET_PC;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (inst_valid) begin
                checks++;
                if (inst_pc !== ep || inst !== mem_word(ep)) begin
                    failures++;
                    $display("[TB] FAIL zero_order got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, ep, mem_word(ep));
                end
                ep = ep + 32'd4;
                delivered++;
            end
            tick();
        end
`ifdef FETCH_ZERO_HALT_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0000);
        checks++;
        if (delivered != 3 || halted !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_halt got delivered=%0d halted=%0b expected 3 halted=1", delivered, halted);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL zero_restart got halted=%0b req=%0b addr=%h expected 0 req=1 addr=00000000",
                     halted, imem_req, imem_addr);
        end
        tick();
`else
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (delivered != 10 || halted !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_passthru got delivered=%0d halted=%0b req=%0b expected 10 halted=0 req=1",
                     delivered, halted, imem_req);
        end
        tick();
`endif
        zero_mode = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic [31:0] exp_req;
        logic [31:0] exp_del;
        logic [31:0] tgt;
        logic [31:0] prev_addr;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        bit          g;
        bit          r;
        bit          rv;
        bit          prev_stall;
        bit          prev_hold;
        bit          prev_redirect;
        int          outstanding;
        int          delivered;
        do_reset();
        exp_req       = RESET_PC;
        exp_del       = RESET_PC;
        outstanding   = 0;
        delivered     = 0;
        prev_stall    = 1'b0;
        prev_hold     = 1'b0;
        prev_redirect = 1'b0;
        prev_addr     = 32'h0;
        prev_inst     = 32'h0;
        prev_pc       = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            g   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 39) == 0);
            tgt = $urandom;
            applyStimulus(g, r, rv, tgt);
            if (prev_redirect) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rnd_flush n=%0d got valid=%0b expected 0", n, inst_valid);
                end
            end
            if (prev_stall && !rv) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    failures++;
                    $display("[TB] FAIL rnd_req_hold n=%0d got req=%0b addr=%h expected req=1 addr=%h", n, imem_req, imem_addr, prev_addr);
                end
            end
            if (prev_hold) begin
                checks++;
                if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc) begin
                    failures++;
                    $display("[TB] FAIL rnd_head_hold n=%0d got valid=%0b pc=%h inst=%h expected 1 pc=%h inst=%h",
                             n, inst_valid, inst_pc, inst, prev_pc, prev_inst);
                end
            end
            if (rv) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rnd_redir_req n=%0d got req=%0b expected 0", n, imem_req);
                end
            end else begin
                if (imem_req && imem_gnt) begin
                    checks++;
                    if (imem_addr !== exp_req) begin
                        failures++;
                        $display("[TB] FAIL rnd_req_addr n=%0d got addr=%h expected %h", n, imem_addr, exp_req);
                    end
                    exp_req = exp_req + 32'd4;
                    outstanding++;
                end
                if (inst_valid && inst_ready) begin
                    checks++;
                    if (inst_pc !== exp_del || inst !== mem_word(exp_del)) begin
                        failures++;
                        $display("[TB] FAIL rnd_deliver n=%0d got pc=%h inst=%h expected pc=%h inst=%h",
                                 n, inst_pc, inst, exp_del, mem_word(exp_del));
                    end
                    exp_del = exp_del + 32'd4;
                    outstanding--;
                    delivered++;
                end
                checks++;
                if (outstanding < 0 || outstanding > DEPTH) begin
                    failures++;
                    $display("[TB] FAIL rnd_credit n=%0d got outstanding=%0d expected 0..%0d", n, outstanding, DEPTH);
                end
            end
            if (rv) begin
                exp_req     = tgt & ~32'h3;
                exp_del     = tgt & ~32'h3;
                outstanding = 0;
            end
            prev_stall    = imem_req && !imem_gnt && !rv;
            prev_addr     = imem_addr;
            prev_hold     = inst_valid && !inst_ready && !rv;
            prev_inst     = inst;
            prev_pc       = inst_pc;
            prev_redirect = rv;
            tick();
        end
        checks++;
        if (delivered < 300) begin
            failures++;
            $display("[TB] FAIL rnd_progress got %0d deliveries expected at least 300", delivered);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rdata     = 32'h0;
        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_wrap();
        test_zero_words();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
